// File: rtl/dmem_port_arbiter_if.sv
// One requester port of the data-memory arbiter: request handshake plus the response pulse.
// The requester uses the master modport, the arbiter uses the slave modport.
interface dmem_port_arbiter_if #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = DATA_WIDTH,
   parameter int DATA_BYTES = DATA_WIDTH/8
);
   logic                  valid;
   logic                  ready;
   logic [ADDR_WIDTH-1:0] addr;
   logic [DATA_WIDTH-1:0] wdata;
   logic [DATA_BYTES-1:0] wen;
   logic                  lock;
   logic                  rsp_valid;
   logic [DATA_WIDTH-1:0] rdata;

   modport master (
      output valid, addr, wdata, wen, lock,
      input  ready, rsp_valid, rdata
   );

   modport slave (
      input  valid, addr, wdata, wen, lock,
      output ready, rsp_valid, rdata
   );
endinterface

// File: rtl/dmem_port_arbiter.sv
// Round-robin arbiter with bounded lock in front of a 1-cycle synchronous data memory.
// Grant and ready are combinational; the response returns one cycle after accept and cannot be stalled.
module dmem_port_arbiter #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = DATA_WIDTH,
   parameter int DATA_BYTES = DATA_WIDTH/8,
   parameter int MAX_LOCK   = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   dmem_port_arbiter_if.slave    p0,
   dmem_port_arbiter_if.slave    p1,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   output logic [DATA_BYTES-1:0] mem_wen,
   input  logic [DATA_WIDTH-1:0] mem_rdata
);

   localparam int CNT_W = $clog2(MAX_LOCK + 1);

   logic [1:0]       req_vld;
   logic             rr_ptr_q,     rr_ptr_d;
   logic             lock_vld_q,   lock_vld_d;
   logic             lock_owner_q, lock_owner_d;
   logic [CNT_W-1:0] lock_cnt_q,   lock_cnt_d;
   logic             rsp_vld_q,    rsp_vld_d;
   logic             rsp_owner_q,  rsp_owner_d;
   logic             rsp_is_rd_q,  rsp_is_rd_d;

   logic                  gnt_vld;
   logic                  gnt_idx;
   logic                  lock_hold;
   logic [ADDR_WIDTH-1:0] gnt_addr;
   logic [DATA_WIDTH-1:0] gnt_wdata;
   logic [DATA_BYTES-1:0] gnt_wen;
   logic                  gnt_lock;
   logic                  rsp0_vld;
   logic                  rsp1_vld;
   logic [DATA_WIDTH-1:0] rsp_rdata;

   assign req_vld = {p1.valid, p0.valid};

   // Grant: a live lock wins unless it has used up its budget while the other port waits.
   always_comb begin
      gnt_vld   = 1'b0;
      gnt_idx   = 1'b0;
      lock_hold = 1'b0;
      if (!rst) begin
         if (lock_vld_q && req_vld[lock_owner_q]) begin
            gnt_vld = 1'b1;
            if (req_vld[~lock_owner_q] && (lock_cnt_q == CNT_W'(MAX_LOCK))) begin
               gnt_idx = ~lock_owner_q;
            end else begin
               gnt_idx   = lock_owner_q;
               lock_hold = 1'b1;
            end
         end else if (&req_vld) begin
            gnt_vld = 1'b1;
            gnt_idx = rr_ptr_q;
         end else if (req_vld[0]) begin
            gnt_vld = 1'b1;
            gnt_idx = 1'b0;
         end else if (req_vld[1]) begin
            gnt_vld = 1'b1;
            gnt_idx = 1'b1;
         end
      end
   end

   assign gnt_addr  = gnt_idx ? p1.addr  : p0.addr;
   assign gnt_wdata = gnt_idx ? p1.wdata : p0.wdata;
   assign gnt_wen   = gnt_idx ? p1.wen   : p0.wen;
   assign gnt_lock  = gnt_idx ? p1.lock  : p0.lock;

   // Next state: the lock budget only burns while the other port is actually waiting.
   always_comb begin
      rr_ptr_d     = rr_ptr_q;
      lock_vld_d   = 1'b0;
      lock_owner_d = lock_owner_q;
      lock_cnt_d   = '0;
      rsp_vld_d    = gnt_vld;
      rsp_owner_d  = gnt_idx;
      rsp_is_rd_d  = (gnt_wen == '0);
      if (gnt_vld) begin
         rr_ptr_d = ~gnt_idx;
         if (gnt_lock) begin
            lock_vld_d   = 1'b1;
            lock_owner_d = gnt_idx;
            lock_cnt_d   = (lock_hold ? lock_cnt_q : '0) + CNT_W'(req_vld[~gnt_idx]);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rr_ptr_q     <= 1'b0;
         lock_vld_q   <= 1'b0;
         lock_owner_q <= 1'b0;
         lock_cnt_q   <= '0;
         rsp_vld_q    <= 1'b0;
         rsp_owner_q  <= 1'b0;
         rsp_is_rd_q  <= 1'b0;
      end else begin
         rr_ptr_q     <= rr_ptr_d;
         lock_vld_q   <= lock_vld_d;
         lock_owner_q <= lock_owner_d;
         lock_cnt_q   <= lock_cnt_d;
         rsp_vld_q    <= rsp_vld_d;
         rsp_owner_q  <= rsp_owner_d;
         rsp_is_rd_q  <= rsp_is_rd_d;
      end
   end

   // Idle drives zeros so no MMIO address is ever presented without a grant.
   always_comb begin
      mem_addr  = '0;
      mem_wdata = '0;
      mem_wen   = '0;
      if (gnt_vld) begin
         mem_addr  = gnt_addr;
         mem_wdata = gnt_wdata;
         mem_wen   = gnt_wen;
      end
   end

   assign rsp0_vld  = rsp_vld_q && !rst && !rsp_owner_q;
   assign rsp1_vld  = rsp_vld_q && !rst &&  rsp_owner_q;
   assign rsp_rdata = rsp_is_rd_q ? mem_rdata : '0;

   assign p0.ready     = gnt_vld && !gnt_idx;
   assign p1.ready     = gnt_vld &&  gnt_idx;
   assign p0.rsp_valid = rsp0_vld;
   assign p1.rsp_valid = rsp1_vld;
   assign p0.rdata     = rsp0_vld ? rsp_rdata : '0;
   assign p1.rdata     = rsp1_vld ? rsp_rdata : '0;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed bench for dmem_port_arbiter with a 1-cycle byte-enable memory model.
module tb_dmem_port_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_wen;
   logic [31:0] mem_rdata;

   logic [31:0] mem [0:1023];
   logic        ld_en;
   logic [9:0]  ld_addr;
   logic [31:0] ld_dat;

   int n_chk  = 0;
   int n_fail = 0;

   dmem_port_arbiter_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) p0_if ();
   dmem_port_arbiter_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) p1_if ();

   dmem_port_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .DATA_BYTES(4), .MAX_LOCK(4)) u_dut (
      .clk       (clk),
      .rst       (rst),
      .p0        (p0_if),
      .p1        (p1_if),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_wen   (mem_wen),
      .mem_rdata (mem_rdata)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (ld_en) begin
         mem[ld_addr] <= ld_dat;
      end else begin
         for (int b = 0; b < 4; b++) begin
            if (mem_wen[b]) mem[mem_addr[11:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
         end
      end
      mem_rdata <= mem[mem_addr[11:2]];
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drv0(input logic v, input logic [31:0] a, input logic [31:0] wd,
                       input logic [3:0] we, input logic lk);
      p0_if.valid = v; p0_if.addr = a; p0_if.wdata = wd; p0_if.wen = we; p0_if.lock = lk;
   endtask

   task automatic drv1(input logic v, input logic [31:0] a, input logic [31:0] wd,
                       input logic [3:0] we, input logic lk);
      p1_if.valid = v; p1_if.addr = a; p1_if.wdata = wd; p1_if.wen = we; p1_if.lock = lk;
   endtask

   task automatic idle_all();
      drv0(1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
      drv1(1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
   endtask

   task automatic preload(input logic [31:0] byte_addr, input logic [31:0] dat);
      ld_en = 1'b1; ld_addr = byte_addr[11:2]; ld_dat = dat;
      tick();
      ld_en = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      idle_all();
      tick();
      tick();
      rst = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] a0, a1;
      int          n1;
      int          eg  [4] = '{0, 1, 0, 1};
      logic [31:0] ed  [4] = '{32'hA0A0_0000, 32'hB0B0_0000, 32'hA0A0_0001, 32'hB0B0_0001};
      int          eg4 [6] = '{0, 1, 1, 1, 1, 0};

      rst = 1'b1; ld_en = 1'b0; ld_addr = '0; ld_dat = '0;
      idle_all();
      tick();
      preload(32'h100, 32'hDEAD_BEEF);
      preload(32'h200, 32'hCAFE_F00D);
      preload(32'h300, 32'hA0A0_0000);
      preload(32'h304, 32'hA0A0_0001);
      preload(32'h400, 32'hB0B0_0000);
      preload(32'h404, 32'hB0B0_0001);

      // reset state, with a request pending that must not be accepted
      drv0(1'b1, 32'h40, 32'h0, 4'hF, 1'b0);
      @(negedge clk);
      chk("rst_p0_rdy", p0_if.ready, 1'b0);
      chk("rst_p1_rdy", p1_if.ready, 1'b0);
      chk("rst_p0_rsp", p0_if.rsp_valid, 1'b0);
      chk("rst_p1_rsp", p1_if.rsp_valid, 1'b0);
      chk("rst_wen", mem_wen, 4'h0);
      chk("rst_addr", mem_addr, 32'h0);
      tick();
      idle_all();
      rst = 1'b0;

      // 1: single read
      drv0(1'b1, 32'h100, 32'h0, 4'h0, 1'b0);
      @(negedge clk);
      chk("t1_p0_rdy", p0_if.ready, 1'b1);
      chk("t1_p1_rdy", p1_if.ready, 1'b0);
      chk("t1_addr", mem_addr, 32'h100);
      tick();
      idle_all();
      @(negedge clk);
      chk("t1_p0_rsp", p0_if.rsp_valid, 1'b1);
      chk("t1_p0_rdata", p0_if.rdata, 32'hDEAD_BEEF);
      chk("t1_p1_rsp", p1_if.rsp_valid, 1'b0);
      tick();

      // 2: continuous contention alternates
      do_reset();
      a0 = 32'h300; a1 = 32'h400;
      for (int c = 0; c <= 4; c++) begin
         if (c < 4) begin
            drv0(1'b1, a0, 32'h0, 4'h0, 1'b0);
            drv1(1'b1, a1, 32'h0, 4'h0, 1'b0);
         end else begin
            idle_all();
         end
         @(negedge clk);
         if (c < 4) begin
            chk($sformatf("t2_p0_rdy%0d", c), p0_if.ready, eg[c] == 0);
            chk($sformatf("t2_p1_rdy%0d", c), p1_if.ready, eg[c] == 1);
         end
         if (c > 0) begin
            chk($sformatf("t2_p0_rsp%0d", c), p0_if.rsp_valid, eg[c-1] == 0);
            chk($sformatf("t2_p1_rsp%0d", c), p1_if.rsp_valid, eg[c-1] == 1);
            chk($sformatf("t2_rdata%0d", c), (eg[c-1] == 0) ? p0_if.rdata : p1_if.rdata, ed[c-1]);
         end
         if (c < 4) begin
            if (eg[c] == 0) a0 = a0 + 32'h4;
            else            a1 = a1 + 32'h4;
         end
         tick();
      end

      // 3: partial write then read-back
      drv1(1'b1, 32'h200, 32'h1234_5678, 4'b0011, 1'b0);
      @(negedge clk);
      chk("t3_p1_rdy", p1_if.ready, 1'b1);
      chk("t3_wen", mem_wen, 4'b0011);
      chk("t3_wdata", mem_wdata, 32'h1234_5678);
      tick();
      drv1(1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
      drv0(1'b1, 32'h200, 32'h0, 4'h0, 1'b0);
      @(negedge clk);
      chk("t3_p1_ack", p1_if.rsp_valid, 1'b1);
      chk("t3_p1_rdata", p1_if.rdata, 32'h0);
      chk("t3_p0_rdy", p0_if.ready, 1'b1);
      tick();
      idle_all();
      @(negedge clk);
      chk("t3_p0_rsp", p0_if.rsp_valid, 1'b1);
      chk("t3_p0_rdata", p0_if.rdata, 32'hCAFE_5678);
      tick();

      // 4: locked burst bounded at four grants while p0 waits
      do_reset();
      n1 = 0;
      drv0(1'b1, 32'h300, 32'h0, 4'h0, 1'b0);
      for (int c = 0; c < 6; c++) begin
         drv1(1'b1, 32'h500 + 32'(4*n1), 32'(n1), 4'hF, 1'b1);
         @(negedge clk);
         chk($sformatf("t4_p0_rdy%0d", c), p0_if.ready, eg4[c] == 0);
         chk($sformatf("t4_p1_rdy%0d", c), p1_if.ready, eg4[c] == 1);
         chk($sformatf("t4_wen%0d", c), mem_wen, (eg4[c] == 1) ? 4'hF : 4'h0);
         if (eg4[c] == 1) n1++;
         tick();
      end
      for (int c = 0; c < 10 && n1 < 6; c++) begin
         drv1(1'b1, 32'h500 + 32'(4*n1), 32'(n1), 4'hF, 1'b1);
         @(negedge clk);
         if (p1_if.ready) n1++;
         tick();
      end
      chk("t4_p1_done", n1, 6);
      idle_all();
      tick();

      // 5: idle presents nothing to memory
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         chk($sformatf("t5_addr%0d", c), mem_addr, 32'h0);
         chk($sformatf("t5_wen%0d", c), mem_wen, 4'h0);
         chk($sformatf("t5_rsp%0d", c), {p1_if.rsp_valid, p0_if.rsp_valid}, 2'b00);
         tick();
      end

      // 6: reset right after an accept drops the response and restores priority
      do_reset();
      drv0(1'b1, 32'h100, 32'h0, 4'h0, 1'b1);
      @(negedge clk);
      chk("t6_p0_rdy", p0_if.ready, 1'b1);
      tick();
      rst = 1'b1;
      @(negedge clk);
      chk("t6_rst_rsp", p0_if.rsp_valid, 1'b0);
      chk("t6_rst_rdy", p0_if.ready, 1'b0);
      chk("t6_rst_wen", mem_wen, 4'h0);
      tick();
      rst = 1'b0;
      drv0(1'b1, 32'h100, 32'h0, 4'h0, 1'b0);
      drv1(1'b1, 32'h400, 32'h0, 4'h0, 1'b0);
      @(negedge clk);
      chk("t6_post_rsp", p0_if.rsp_valid, 1'b0);
      chk("t6_p0_win", p0_if.ready, 1'b1);
      chk("t6_p1_lose", p1_if.ready, 1'b0);
      tick();
      idle_all();
      @(negedge clk);
      chk("t6_p0_rsp", p0_if.rsp_valid, 1'b1);
      chk("t6_p0_rdata", p0_if.rdata, 32'hDEAD_BEEF);
      tick();

      $display("[TB] %0d tests run, %0d failed", n_chk, n_fail);
      $finish;
   end

endmodule
